// File: rtl/ram_dump_pkg.sv
// Shared types and defaults for the RAM dump arbiter: FSM state encoding and port widths.
package ram_dump_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        PRESENT = 3'd4,
        DONE    = 3'd5
    } dumpState_t;

    localparam int ADDR_W_DEFAULT   = 8;
    localparam int DATA_W_DEFAULT   = 32;
    localparam int RAM_READ_LATENCY = 1;

endpackage

// File: rtl/ram_port_mux.sv
// Combinational select of who drives the single RAM port: the MEM stage or the dump engine.
module ram_port_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              dumpOwns,
    input  logic [3:0]        pipeWe,
    input  logic [ADDR_W-1:0] pipeAddr,
    input  logic [DATA_W-1:0] pipeWdata,
    input  logic [ADDR_W-1:0] dumpAddr,
    output logic [3:0]        ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWdata
);

    // The dump engine only ever reads, so it forces write enables and write data to zero.
    always_comb begin
        ramWe    = pipeWe;
        ramAddr  = pipeAddr;
        ramWdata = pipeWdata;
        if (dumpOwns) begin
            ramWe    = 4'h0;
            ramAddr  = dumpAddr;
            ramWdata = '0;
        end
    end

endmodule

// File: rtl/ram_dump_arbiter.sv
// Freezes the pipeline on a dump request, streams a window of RAM words over valid/ready,
// then returns the RAM port to the MEM stage.
module ram_dump_arbiter
    import ram_dump_pkg::*;
#(
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_WORDS = 256,
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              pipe_hold,
    input  logic              dump_start,
    input  logic              dump_abort,
    output logic              dump_busy,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              dump_done
);

    dumpState_t        state;
    dumpState_t        nextState;
    logic [ADDR_W:0]   idx;
    logic [DATA_W-1:0] wordData;
    logic              wordValid;
    logic              dumpDone;
    logic              lastWord;
    logic              accept;
    logic              dumpOwns;
    logic [ADDR_W-1:0] dumpAddr;

    assign lastWord = (idx == (ADDR_W+1)'(DUMP_WORDS - 1));
    assign accept   = (state == PRESENT) && wordValid && word_ready;

    // Next-state logic; abort overrides every other transition once a dump is under way.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (dump_start && !dump_abort) nextState = DRAIN;
            DRAIN:   nextState = ISSUE;
            ISSUE:   nextState = CAPTURE;
            CAPTURE: nextState = PRESENT;
            PRESENT: if (accept) nextState = lastWord ? DONE : ISSUE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (state != IDLE && dump_abort) begin
            nextState = IDLE;
        end
    end

    // State, word counter and the presented-word register; word_data is captured one cycle
    // after the address was issued because the RAM output is registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            wordData  <= '0;
            wordValid <= 1'b0;
            dumpDone  <= 1'b0;
        end else begin
            state     <= nextState;
            wordValid <= (nextState == PRESENT);
            dumpDone  <= (nextState == DONE);
            if (state == IDLE && nextState == DRAIN) begin
                idx <= '0;
            end else if (accept && !dump_abort) begin
                idx <= idx + 1'b1;
            end
            if (state == CAPTURE && nextState == PRESENT) begin
                wordData <= ram_rdata;
            end
        end
    end

    // Drain and done still hand the port to the pipeline so a frozen store completes or
    // harmlessly rewrites the same location.
    assign dumpOwns = (state == ISSUE) || (state == CAPTURE) || (state == PRESENT);
    assign dumpAddr = ADDR_W'(DUMP_BASE) + idx[ADDR_W-1:0];

    ram_port_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) portMux (
        .dumpOwns (dumpOwns),
        .pipeWe   (pipe_we),
        .pipeAddr (pipe_addr),
        .pipeWdata(pipe_wdata),
        .dumpAddr (dumpAddr),
        .ramWe    (ram_we),
        .ramAddr  (ram_addr),
        .ramWdata (ram_wdata)
    );

    assign pipe_rdata = ram_rdata;
    assign pipe_hold  = (state != IDLE);
    assign dump_busy  = (state != IDLE);
    assign word_data  = wordData;
    assign word_valid = wordValid;
    assign dump_done  = dumpDone;

endmodule

// File: tb/tb_ram_dump_arbiter.sv
// Directed bench for ram_dump_arbiter: a full-window instance on a modelled RAM and a
// small wrapping-window instance whose RAM returns the address it was given.
module tb_ram_dump_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  pipeWe;
    logic [7:0]  pipeAddr;
    logic [31:0] pipeWdata;
    logic [31:0] pipeRdata;
    logic [3:0]  ramWe;
    logic [7:0]  ramAddr;
    logic [31:0] ramWdata;
    logic [31:0] ramRdata;
    logic        pipeHold;
    logic        dumpStart;
    logic        dumpAbort;
    logic        dumpBusy;
    logic [31:0] wordData;
    logic        wordValid;
    logic        wordReady;
    logic        dumpDone;

    logic [31:0] pipeRdata1;
    logic [3:0]  ramWe1;
    logic [7:0]  ramAddr1;
    logic [31:0] ramWdata1;
    logic [31:0] ramRdata1;
    logic        pipeHold1;
    logic        dumpStart1;
    logic        dumpBusy1;
    logic [31:0] wordData1;
    logic        wordValid1;
    logic        dumpDone1;

    int vectorCount = 0;
    int missCount   = 0;

    logic [31:0] mem0 [256];
    logic [31:0] captured [256];
    int wordCount, doneCount, doneTick, holdLow, weBad;

    ram_dump_arbiter #(.DUMP_BASE(0), .DUMP_WORDS(256), .ADDR_W(8), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .pipe_we(pipeWe), .pipe_addr(pipeAddr), .pipe_wdata(pipeWdata), .pipe_rdata(pipeRdata),
        .ram_we(ramWe), .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_rdata(ramRdata),
        .pipe_hold(pipeHold), .dump_start(dumpStart), .dump_abort(dumpAbort), .dump_busy(dumpBusy),
        .word_data(wordData), .word_valid(wordValid), .word_ready(wordReady), .dump_done(dumpDone)
    );

    ram_dump_arbiter #(.DUMP_BASE(250), .DUMP_WORDS(10), .ADDR_W(8), .DATA_W(32)) dutWrap (
        .clock(clock), .reset(reset),
        .pipe_we(pipeWe), .pipe_addr(pipeAddr), .pipe_wdata(pipeWdata), .pipe_rdata(pipeRdata1),
        .ram_we(ramWe1), .ram_addr(ramAddr1), .ram_wdata(ramWdata1), .ram_rdata(ramRdata1),
        .pipe_hold(pipeHold1), .dump_start(dumpStart1), .dump_abort(1'b0), .dump_busy(dumpBusy1),
        .word_data(wordData1), .word_valid(wordValid1), .word_ready(1'b1), .dump_done(dumpDone1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte-enabled RAM with a registered read port
    always @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (ramWe[b]) mem0[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
        end
        ramRdata <= mem0[ramAddr];
    end

    // The wrap instance's RAM simply echoes the address it was read at
    always @(posedge clock) begin
        ramRdata1 <= {24'h0, ramAddr1};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitValid(input int budget, input string tag);
        int n;
        n = 0;
        while (!wordValid && n < budget) begin
            tick();
            n++;
        end
        if (!wordValid) checkOutput(tag, 32'(wordValid), 32'd1);
    endtask

    // Starts a dump with word_ready high and records everything seen for 800 cycles
    task automatic applyStimulus(input bit withStore);
        dumpStart = 1'b1;
        wordReady = 1'b1;
        if (withStore) begin
            pipeWe    = 4'hF;
            pipeAddr  = 8'h03;
            pipeWdata = 32'hDEADBEEF;
        end
        tick();
        dumpStart = 1'b0;
        wordCount = 0;
        doneCount = 0;
        doneTick  = -1;
        holdLow   = 0;
        weBad     = 0;
        for (int t = 0; t < 800; t++) begin
            if (t < 770 && !pipeHold) holdLow++;
            if (t >= 1 && t <= 768 && ramWe != 4'h0) weBad++;
            if (!withStore && t == 1) checkOutput("first_dump_addr", 32'(ramAddr), 32'h0);
            if (wordValid && wordReady && wordCount < 256) begin
                captured[wordCount] = wordData;
                wordCount++;
            end
            if (dumpDone) begin
                doneCount++;
                doneTick = t;
            end
            tick();
        end
        pipeWe = 4'h0;
    endtask

    initial begin
        int n1, done1, bad;
        logic [7:0] expAddr;

        reset      = 1'b1;
        pipeWe     = 4'hF;
        pipeAddr   = 8'h10;
        pipeWdata  = 32'h0;
        dumpStart  = 1'b0;
        dumpStart1 = 1'b0;
        dumpAbort  = 1'b0;
        wordReady  = 1'b0;
        #3;
        checkOutput("rst_hold", 32'(pipeHold), 32'd0);
        checkOutput("rst_busy", 32'(dumpBusy), 32'd0);
        checkOutput("rst_valid", 32'(wordValid), 32'd0);
        checkOutput("rst_data", wordData, 32'h0);
        checkOutput("rst_done", 32'(dumpDone), 32'd0);
        checkOutput("rst_we_pass", 32'(ramWe), 32'hF);
        checkOutput("rst_addr_pass", 32'(ramAddr), 32'h10);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 256; i++) begin
            pipeWe    = 4'hF;
            pipeAddr  = 8'(i);
            pipeWdata = 32'hA5000000 + 32'(i);
            #1;
            if (i == 7) checkOutput("pass_wdata", ramWdata, 32'hA5000007);
            tick();
        end
        pipeWe = 4'h0;
        tick();
        checkOutput("pipe_rdata", pipeRdata, ramRdata);

        // Full dump, ready always high
        applyStimulus(1'b0);
        checkOutput("full_count", 32'(wordCount), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (captured[i] !== 32'hA5000000 + 32'(i)) bad++;
        end
        checkOutput("full_words_bad", 32'(bad), 32'd0);
        checkOutput("full_word0", captured[0], 32'hA5000000);
        checkOutput("full_word255", captured[255], 32'hA50000FF);
        checkOutput("full_done_count", 32'(doneCount), 32'd1);
        checkOutput("full_done_tick", 32'(doneTick), 32'd769);
        checkOutput("full_hold_low", 32'(holdLow), 32'd0);
        checkOutput("full_hold_after", 32'(pipeHold), 32'd0);

        // Dump with a store frozen in MEM
        applyStimulus(1'b1);
        checkOutput("store_word3", captured[3], 32'hDEADBEEF);
        checkOutput("store_word4", captured[4], 32'hA5000004);
        checkOutput("store_we_zero", 32'(weBad), 32'd0);
        checkOutput("store_done_count", 32'(doneCount), 32'd1);

        // Backpressure on word 0
        dumpStart = 1'b1;
        wordReady = 1'b0;
        tick();
        dumpStart = 1'b0;
        waitValid(10, "bp_timeout");
        checkOutput("bp_word0", wordData, 32'hA5000000);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!wordValid || wordData !== 32'hA5000000) bad++;
        end
        checkOutput("bp_stable", 32'(bad), 32'd0);
        wordReady = 1'b1;
        tick();
        checkOutput("bp_gap1", 32'(wordValid), 32'd0);
        tick();
        checkOutput("bp_gap2", 32'(wordValid), 32'd0);
        tick();
        checkOutput("bp_word1_valid", 32'(wordValid), 32'd1);
        checkOutput("bp_word1", wordData, 32'hA5000001);

        // A start while busy must not restart the sequence
        dumpStart = 1'b1;
        tick();
        dumpStart = 1'b0;
        waitValid(6, "seq2_timeout");
        checkOutput("seq_word2", wordData, 32'hA5000002);
        tick();
        waitValid(6, "seq3_timeout");
        checkOutput("seq_word3", wordData, 32'hDEADBEEF);
        tick();
        waitValid(6, "seq4_timeout");
        checkOutput("seq_word4", wordData, 32'hA5000004);

        // Abort beats word_ready during PRESENT
        dumpAbort = 1'b1;
        tick();
        dumpAbort = 1'b0;
        checkOutput("abort_hold", 32'(pipeHold), 32'd0);
        checkOutput("abort_valid", 32'(wordValid), 32'd0);
        checkOutput("abort_busy", 32'(dumpBusy), 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (dumpDone) bad++;
            tick();
        end
        checkOutput("abort_no_done", 32'(bad), 32'd0);

        // Fresh dump restarts at the base address
        dumpStart = 1'b1;
        wordReady = 1'b0;
        tick();
        dumpStart = 1'b0;
        waitValid(10, "restart_timeout");
        checkOutput("restart_word0", wordData, 32'hA5000000);
        checkOutput("restart_addr", 32'(ramAddr), 32'h0);
        dumpAbort = 1'b1;
        tick();
        dumpAbort = 1'b0;
        checkOutput("restart_abort_busy", 32'(dumpBusy), 32'd0);

        // Start and abort together in IDLE
        dumpStart = 1'b1;
        dumpAbort = 1'b1;
        tick();
        dumpStart = 1'b0;
        dumpAbort = 1'b0;
        checkOutput("both_idle_hold", 32'(pipeHold), 32'd0);
        tick();
        checkOutput("both_idle_busy", 32'(dumpBusy), 32'd0);

        // Wrapping window on the second instance
        dumpStart1 = 1'b1;
        tick();
        dumpStart1 = 1'b0;
        checkOutput("wrap_hold", 32'(pipeHold1), 32'd1);
        n1 = 0;
        done1 = 0;
        bad = 0;
        for (int t = 0; t < 60; t++) begin
            if (wordValid1) begin
                expAddr = 8'(250 + n1);
                if (n1 >= 10 || ramAddr1 !== expAddr || wordData1 !== {24'h0, expAddr}) bad++;
                if (ramWe1 != 4'h0) bad++;
                n1++;
            end
            if (dumpDone1) begin
                done1++;
                if (n1 != 10) bad++;
            end
            tick();
        end
        checkOutput("wrap_seq_bad", 32'(bad), 32'd0);
        checkOutput("wrap_count", 32'(n1), 32'd10);
        checkOutput("wrap_done", 32'(done1), 32'd1);
        checkOutput("wrap_busy_after", 32'(dumpBusy1), 32'd0);
        checkOutput("wrap_rdata_pass", pipeRdata1, ramRdata1);
        checkOutput("wrap_wdata_pass", ramWdata1, pipeWdata);

        // Asynchronous reset in PRESENT with idx = 5
        dumpStart = 1'b1;
        wordReady = 1'b1;
        tick();
        dumpStart = 1'b0;
        bad = 1;
        for (int t = 0; t < 40; t++) begin
            if (wordValid && wordData === 32'hA5000005) begin
                bad = 0;
                break;
            end
            tick();
        end
        wordReady = 1'b0;
        checkOutput("mid_reach_word5", 32'(bad), 32'd0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_hold", 32'(pipeHold), 32'd0);
        checkOutput("mid_rst_busy", 32'(dumpBusy), 32'd0);
        checkOutput("mid_rst_valid", 32'(wordValid), 32'd0);
        checkOutput("mid_rst_data", wordData, 32'h0);
        checkOutput("mid_rst_done", 32'(dumpDone), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        pipeWe   = 4'hF;
        pipeAddr = 8'h10;
        #1;
        checkOutput("post_rst_we", 32'(ramWe), 32'hF);
        checkOutput("post_rst_addr", 32'(ramAddr), 32'h10);
        pipeWe = 4'h0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/ram_dump_arbiter.md
# ram_dump_arbiter

Shares the single port of the data RAM between the pipeline MEM stage and a sequential dump engine. On a dump request it freezes the pipeline, takes the RAM port, and streams a window of RAM words to a downstream consumer (the debug/UART serializer) over a valid/ready handshake. It then hands the port back to the pipeline. It sits between the EX/MEM latch outputs and the RAM, replacing the ad-hoc address/write-enable muxing around the RAM.

## Interface
- DUMP_BASE, 0: first word address dumped.
- DUMP_WORDS, 256: number of words per dump, 1..256.
- ADDR_W, 8: RAM address width.
- DATA_W, 32: RAM word width.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high.
- pipe_we  in  4  byte write enables from the MEM stage.
- pipe_addr  in  ADDR_W  MEM-stage address.
- pipe_wdata  in  DATA_W  MEM-stage store data.
- pipe_rdata  out  DATA_W  RAM read data to the MEM stage; always equal to ram_rdata.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM output; registered, 1-cycle read latency.
- pipe_hold  out  1  high freezes all pipeline latches and the PC.
- dump_start  in  1  single-cycle request to start a dump.
- dump_abort  in  1  cancels a dump in progress.
- dump_busy  out  1  high in every state except IDLE.
- word_data  out  DATA_W  dumped word.
- word_valid  out  1  word_data is valid.
- word_ready  in  1  consumer accepts word_data.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, DRAIN, ISSUE, CAPTURE, PRESENT, DONE.
- IDLE:
  - ram_we/addr/wdata pass through pipe_we/addr/wdata combinationally.
  - pipe_hold = 0.
  - dump_start = 1 moves to DRAIN and clears idx.
- DRAIN (1 cycle):
  - pipe_hold = 1.
  - The port is still given to the pipeline, so any store already in MEM completes.
  - Moves to ISSUE.
- ISSUE:
  - The port is owned by the dump engine: ram_we = 0, ram_addr = (DUMP_BASE + idx) mod 2^ADDR_W, ram_wdata = 0.
  - Moves to CAPTURE.
- CAPTURE:
  - ram_addr is held.
  - word_data is loaded from ram_rdata and word_valid is set.
  - Moves to PRESENT.
- PRESENT:
  - word_data and word_valid are held stable until word_valid & word_ready.
  - On acceptance: word_valid is cleared next cycle and idx increments. The next state is DONE if idx == DUMP_WORDS-1, otherwise ISSUE.
- DONE (1 cycle):
  - dump_done = 1.
  - pipe_hold is still high.
  - Returns to IDLE; pipe_hold falls on that edge.
- pipe_hold is high in DRAIN, ISSUE, CAPTURE, PRESENT and DONE.
- A store frozen in MEM is rewritten when the port returns to the pipeline. The rewrite is idempotent (same address and data), so this is the required behaviour.
- idx is an ADDR_W+1-bit counter. Address generation wraps modulo 2^ADDR_W; for example, DUMP_BASE = 250 with DUMP_WORDS = 10 reads 250..255, then 0..3.
- dump_start while dump_busy is ignored.
- dump_abort in any non-IDLE state:
  - Next state is IDLE; word_valid and pipe_hold drop on that edge.
  - No dump_done.
  - dump_abort has priority over word_ready and over the DONE transition.
- dump_start and dump_abort both high in IDLE: stays IDLE.
- word_ready while word_valid = 0 is ignored.

## Timing
- Reset values:
  - state IDLE, idx 0.
  - pipe_hold 0, dump_busy 0, word_valid 0, word_data 0, dump_done 0.
  - ram_* follow pipe_* combinationally.
- dump_start at edge t:
  - pipe_hold = 1 from t+1.
  - First dump address on ram_addr at t+2.
  - word_valid at t+4.
- With word_ready held high, throughput is 1 word per 3 cycles (ISSUE, CAPTURE, PRESENT).
- A full 256-word dump with ready high takes 1 + 768 + 1 = 770 cycles from DRAIN entry to IDLE.
- State register, idx, word_data, word_valid and dump_done are registered.
- pipe_hold and dump_busy are decoded from the registered state (glitch-free, no combinational path from inputs).
- The RAM port mux is combinational on state only.

## Structure
- Shared package (ram_dump_pkg):
  - State enum encoding.
  - ADDR_W and DATA_W defaults.
  - RAM_READ_LATENCY = 1.
- One sub-module: ram_port_mux, the combinational select of the pipeline vs dump-engine address/we/wdata, driven by a single owner bit.
- FSM, counter and output register live in the top module.

## Test plan
- Reset mid-PRESENT (idx = 5):
  - Response: all outputs return to their reset values asynchronously.
  - Response: after deassertion, pipe_we = 4'hF at pipe_addr 0x10 reaches ram_we/ram_addr directly.
- RAM preloaded with word[i] = 0xA5000000 + i; dump_start; word_ready always high:
  - Response: 256 words 0xA5000000..0xA50000FF in order.
  - Response: dump_done exactly once, 770 cycles after DRAIN entry.
  - Response: pipe_hold high throughout and low afterwards.
- Store (pipe_we = 4'hF, addr 0x03, data 0xDEADBEEF) present in the dump_start cycle:
  - Response: word 3 of the dump reads 0xDEADBEEF.
  - Response: ram_we = 0 in every ISSUE, CAPTURE and PRESENT cycle.
- Backpressure, with word_ready low for 7 cycles on word 0:
  - Response: word_valid and word_data stay stable with no idx advance.
  - Response: word 1 is presented 3 cycles after acceptance.
- DUMP_BASE = 250, DUMP_WORDS = 10:
  - Response: ram_addr sequence 250..255, 0..3, then dump_done.
- dump_abort during PRESENT of word 4:
  - Response: IDLE on the next cycle, with pipe_hold and word_valid low and no dump_done.
  - Response: a second dump_start during a dump is ignored, and a fresh dump restarts at DUMP_BASE.
